// File: rtl/spif_pkg.sv
// Shared SpiNNaker packet field positions and router types.
package spif_pkg;
    localparam int unsigned PACKET_BITS = 72;
    localparam int unsigned KEY_LSB     = 8;
    localparam int unsigned KEY_MSB     = 39;
    localparam int unsigned KEY_BITS    = KEY_MSB - KEY_LSB + 1;
    localparam int unsigned NUM_RREGS   = 16;
    localparam int unsigned NUM_ROUTES  = 4;
    localparam int unsigned ROUTE_BITS  = $clog2(NUM_ROUTES);

    typedef logic [PACKET_BITS-1:0] packet_t;
    typedef logic [KEY_BITS-1:0]    key_t;
    typedef logic [ROUTE_BITS-1:0]  route_t;
    typedef logic [NUM_ROUTES-1:0]  link_vec_t;

    function automatic link_vec_t route_onehot(route_t r);
        return link_vec_t'(1) << r;
    endfunction
endpackage

// File: rtl/pkt_router_if.sv
// Packet handshake bundle: upstream packet input and shared-data, per-link-valid output.
interface pkt_router_if;
    import spif_pkg::*;

    packet_t   pkt_data_in;
    logic      pkt_vld_in;
    logic      pkt_rdy_out;
    packet_t   pkt_data_out;
    link_vec_t pkt_vld_out;
    link_vec_t pkt_rdy_in;

    modport master (
        output pkt_data_in, pkt_vld_in, pkt_rdy_in,
        input  pkt_rdy_out, pkt_data_out, pkt_vld_out
    );

    modport slave (
        input  pkt_data_in, pkt_vld_in, pkt_rdy_in,
        output pkt_rdy_out, pkt_data_out, pkt_vld_out
    );
endinterface

// File: rtl/pkt_router_match.sv
// Combinational key/mask priority matcher: lowest-index hitting entry selects the route.
module pkt_router_match
    import spif_pkg::*;
(
    input  key_t   key,
    input  key_t   rt_key [NUM_RREGS],
    input  key_t   rt_msk [NUM_RREGS],
    input  route_t rt_rte [NUM_RREGS],
    output logic   hit,
    output route_t route
);
    always_comb begin
        hit   = 1'b0;
        route = '0;
        for (int i = 0; i < NUM_RREGS; i++) begin
            if (!hit && ((key & rt_msk[i]) == rt_key[i])) begin
                hit   = 1'b1;
                route = rt_rte[i];
            end
        end
    end
endmodule

// File: rtl/pkt_router.sv
// Key/mask packet router with a one-packet output register and drop counter.
// PKT_ROUTER_SKID_EN adds a skid register so pkt_rdy_out is a pure register output.
module pkt_router
    import spif_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  key_t        rt_key_in [NUM_RREGS],
    input  key_t        rt_msk_in [NUM_RREGS],
    input  route_t      rt_rte_in [NUM_RREGS],
    pkt_router_if.slave pkt,
    output logic [31:0] drop_cnt_out
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state_q;
    packet_t     data_q;
    route_t      rte_q;
    link_vec_t   vld_q;
    logic [31:0] drop_q;
    logic        rdy;
    logic        hit;
    route_t      route;
    logic        accept;
    logic        drain;

    pkt_router_match u_match (
        .key    (pkt.pkt_data_in[KEY_MSB:KEY_LSB]),
        .rt_key (rt_key_in),
        .rt_msk (rt_msk_in),
        .rt_rte (rt_rte_in),
        .hit    (hit),
        .route  (route)
    );

    // Only the held packet's own link can drain it.
    assign drain  = (state_q == FULL) && pkt.pkt_rdy_in[rte_q];
    assign accept = pkt.pkt_vld_in && rdy;

    // Saturating count of accepted packets that hit no entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (accept && !hit && (drop_q != '1)) begin
            drop_q <= drop_q + 32'd1;
        end
    end

`ifdef PKT_ROUTER_SKID_EN
    logic    rdy_q;
    logic    skid_full_q;
    packet_t skid_data_q;
    route_t  skid_rte_q;

    assign rdy = rdy_q;

    // Output FSM; a packet accepted while stalled parks in the skid and must drain first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            data_q      <= '0;
            rte_q       <= '0;
            vld_q       <= '0;
            rdy_q       <= 1'b0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_rte_q  <= '0;
        end else if (skid_full_q) begin
            if (drain) begin
                data_q      <= skid_data_q;
                rte_q       <= skid_rte_q;
                vld_q       <= route_onehot(skid_rte_q);
                skid_full_q <= 1'b0;
                rdy_q       <= 1'b1;
            end
        end else begin
            rdy_q <= 1'b1;
            if (accept && hit) begin
                if ((state_q == EMPTY) || drain) begin
                    state_q <= FULL;
                    data_q  <= pkt.pkt_data_in;
                    rte_q   <= route;
                    vld_q   <= route_onehot(route);
                end else begin
                    skid_full_q <= 1'b1;
                    skid_data_q <= pkt.pkt_data_in;
                    skid_rte_q  <= route;
                    rdy_q       <= 1'b0;
                end
            end else if (drain) begin
                state_q <= EMPTY;
                vld_q   <= '0;
            end
        end
    end
`else
    logic up_q;

    // up_q holds ready low until the first edge after reset release.
    assign rdy = up_q && ((state_q == EMPTY) || drain);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            rte_q   <= '0;
            vld_q   <= '0;
            up_q    <= 1'b0;
        end else begin
            up_q <= 1'b1;
            if (accept && hit) begin
                state_q <= FULL;
                data_q  <= pkt.pkt_data_in;
                rte_q   <= route;
                vld_q   <= route_onehot(route);
            end else if (drain) begin
                state_q <= EMPTY;
                vld_q   <= '0;
            end
        end
    end
`endif

    assign pkt.pkt_rdy_out  = rdy;
    assign pkt.pkt_data_out = data_q;
    assign pkt.pkt_vld_out  = vld_q;
    assign drop_cnt_out     = drop_q;
endmodule

// File: tb/tb_pkt_router.sv
// Self-checking bench for pkt_router: directed scenarios plus randomized streaming against a queue model.
module tb_pkt_router;
    import spif_pkg::*;

    logic        clk_tb;
    logic        reset_tb;
    key_t        rt_key [NUM_RREGS];
    key_t        rt_msk [NUM_RREGS];
    route_t      rt_rte [NUM_RREGS];
    logic [31:0] drop_cnt;

    pkt_router_if bus_if ();

    pkt_router u_dut (
        .clk          (clk_tb),
        .reset_n      (reset_tb),
        .rt_key_in    (rt_key),
        .rt_msk_in    (rt_msk),
        .rt_rte_in    (rt_rte),
        .pkt          (bus_if),
        .drop_cnt_out (drop_cnt)
    );

    int      checks;
    int      errors;
    int      n_deliv;
    int      exp_drops;
    logic    acc_seen;
    packet_t exp_data_q [$];
    route_t  exp_rte_q  [$];

    initial begin
        clk_tb = 1'b0;
        forever #5 clk_tb = ~clk_tb;
    end

    // Routing rule straight from the table: first entry whose masked key matches, else drop.
    function automatic int model_route(key_t k);
        for (int i = 0; i < NUM_RREGS; i++) begin
            if ((k & rt_msk[i]) == rt_key[i]) return int'(rt_rte[i]);
        end
        return -1;
    endfunction

    function automatic packet_t mk_pkt(key_t k);
        return {32'($urandom), k, 8'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic disable_all();
        for (int i = 0; i < NUM_RREGS; i++) begin
            rt_key[i] = 32'hFFFF_FFFF;
            rt_msk[i] = '0;
            rt_rte[i] = '0;
        end
    endtask

    // Scoreboard: model accepts, check each delivery in order on the right link, and stall stability.
    initial begin : scoreboard
        link_vec_t prev_vld;
        packet_t   prev_data;
        logic      stalled;
        packet_t   p;
        route_t    rr;
        int        r;
        stalled   = 1'b0;
        prev_vld  = '0;
        prev_data = '0;
        acc_seen  = 1'b0;
        n_deliv   = 0;
        exp_drops = 0;
        forever begin
            @(negedge clk_tb);
            if (!reset_tb) begin
                exp_data_q.delete();
                exp_rte_q.delete();
                exp_drops = 0;
                stalled   = 1'b0;
                acc_seen  = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (bus_if.pkt_vld_out !== prev_vld || bus_if.pkt_data_out !== prev_data) begin
                        errors++;
                        $display("FAIL stall_stable: vld=%b data=%h, required vld=%b data=%h",
                                 bus_if.pkt_vld_out, bus_if.pkt_data_out, prev_vld, prev_data);
                    end
                end
                stalled = 1'b0;
                if (bus_if.pkt_vld_out != '0) begin
                    checks++;
                    if (!$onehot(bus_if.pkt_vld_out)) begin
                        errors++;
                        $display("FAIL vld_onehot: vld=%b, required one-hot", bus_if.pkt_vld_out);
                    end
                    if ((bus_if.pkt_vld_out & bus_if.pkt_rdy_in) != '0) begin
                        checks++;
                        if (exp_data_q.size() == 0) begin
                            errors++;
                            $display("FAIL spurious_delivery: vld=%b data=%h, required no packet",
                                     bus_if.pkt_vld_out, bus_if.pkt_data_out);
                        end else begin
                            p  = exp_data_q.pop_front();
                            rr = exp_rte_q.pop_front();
                            n_deliv++;
                            if (bus_if.pkt_data_out !== p || bus_if.pkt_vld_out !== link_vec_t'(1 << rr)) begin
                                errors++;
                                $display("FAIL delivery: vld=%b data=%h, required vld=%b data=%h",
                                         bus_if.pkt_vld_out, bus_if.pkt_data_out, link_vec_t'(1 << rr), p);
                            end
                        end
                    end else begin
                        stalled   = 1'b1;
                        prev_vld  = bus_if.pkt_vld_out;
                        prev_data = bus_if.pkt_data_out;
                    end
                end
                acc_seen = bus_if.pkt_vld_in && bus_if.pkt_rdy_out;
                if (acc_seen) begin
                    r = model_route(bus_if.pkt_data_in[KEY_MSB:KEY_LSB]);
                    if (r < 0) begin
                        exp_drops++;
                    end else begin
                        exp_data_q.push_back(bus_if.pkt_data_in);
                        exp_rte_q.push_back(route_t'(r));
                    end
                end
            end
        end
    end

    task automatic test_reset();
        #2 reset_tb = 1'b0;
        repeat (2) @(posedge clk_tb);
        #1;
        checks++;
        if (bus_if.pkt_vld_out !== '0) begin errors++; $display("FAIL rst_vld: got %b, required 0", bus_if.pkt_vld_out); end
        checks++;
        if (bus_if.pkt_data_out !== '0) begin errors++; $display("FAIL rst_data: got %h, required 0", bus_if.pkt_data_out); end
        checks++;
        if (bus_if.pkt_rdy_out !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b, required 0", bus_if.pkt_rdy_out); end
        checks++;
        if (drop_cnt !== 32'd0) begin errors++; $display("FAIL rst_drop: got %0d, required 0", drop_cnt); end
        @(negedge clk_tb);
        #1 reset_tb = 1'b1;
        #1;
        checks++;
        if (bus_if.pkt_rdy_out !== 1'b0) begin errors++; $display("FAIL rst_rdy_early: got %b, required 0", bus_if.pkt_rdy_out); end
        tick();
        checks++;
        if (bus_if.pkt_rdy_out !== 1'b1) begin errors++; $display("FAIL rst_rdy_rise: got %b, required 1", bus_if.pkt_rdy_out); end
    endtask

    task automatic test_basic_route();
        packet_t p1, p2;
        disable_all();
        rt_key[0] = 32'hEE00_0000; rt_msk[0] = 32'hFF00_0000; rt_rte[0] = 2'd2;
        rt_key[1] = 32'h0;         rt_msk[1] = 32'h0;         rt_rte[1] = 2'd1;
        bus_if.pkt_rdy_in = 4'b1111;
        p1 = mk_pkt(32'hEE12_3456);
        p2 = mk_pkt(32'h1100_0001);
        bus_if.pkt_data_in = p1;
        bus_if.pkt_vld_in  = 1'b1;
        tick();
        checks++;
        if (bus_if.pkt_vld_out !== 4'b0100 || bus_if.pkt_data_out !== p1) begin
            errors++;
            $display("FAIL basic_first: vld=%b data=%h, required vld=0100 data=%h", bus_if.pkt_vld_out, bus_if.pkt_data_out, p1);
        end
        bus_if.pkt_data_in = p2;
        tick();
        checks++;
        if (bus_if.pkt_vld_out !== 4'b0010 || bus_if.pkt_data_out !== p2) begin
            errors++;
            $display("FAIL basic_second: vld=%b data=%h, required vld=0010 data=%h", bus_if.pkt_vld_out, bus_if.pkt_data_out, p2);
        end
        bus_if.pkt_vld_in = 1'b0;
        tick();
        checks++;
        if (bus_if.pkt_vld_out !== 4'b0000) begin errors++; $display("FAIL basic_idle: vld=%b, required 0000", bus_if.pkt_vld_out); end
    endtask

    task automatic test_drop();
        disable_all();
        bus_if.pkt_rdy_in = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bus_if.pkt_data_in = mk_pkt(key_t'($urandom));
            bus_if.pkt_vld_in  = 1'b1;
            tick();
            checks++;
            if (acc_seen !== 1'b1) begin errors++; $display("FAIL drop_accept: accepted=%b, required 1", acc_seen); end
            checks++;
            if (bus_if.pkt_vld_out !== '0) begin errors++; $display("FAIL drop_vld: vld=%b, required 0000", bus_if.pkt_vld_out); end
        end
        bus_if.pkt_vld_in = 1'b0;
        checks++;
        if (drop_cnt !== 32'd5) begin errors++; $display("FAIL drop_count: got %0d, required 5", drop_cnt); end
        checks++;
        if (bus_if.pkt_rdy_out !== 1'b1) begin errors++; $display("FAIL drop_rdy: got %b, required 1", bus_if.pkt_rdy_out); end
    endtask

    task automatic test_backpressure();
        packet_t a, b;
        int      base;
        logic    exp_acc;
        disable_all();
        rt_key[0] = '0; rt_msk[0] = '0; rt_rte[0] = 2'd2;
        bus_if.pkt_rdy_in = 4'b1111;
        a = mk_pkt(key_t'($urandom));
        b = mk_pkt(key_t'($urandom));
        bus_if.pkt_data_in = a;
        bus_if.pkt_vld_in  = 1'b1;
        tick();
        checks++;
        if (acc_seen !== 1'b1) begin errors++; $display("FAIL bp_accept_a: accepted=%b, required 1", acc_seen); end
        base = n_deliv;
        bus_if.pkt_data_in = b;
        bus_if.pkt_rdy_in  = 4'b1011;
        for (int c = 0; c < 10; c++) begin
            tick();
`ifdef PKT_ROUTER_SKID_EN
            exp_acc = (c == 0);
`else
            exp_acc = 1'b0;
`endif
            checks++;
            if (acc_seen !== exp_acc) begin errors++; $display("FAIL bp_accept_b: cycle %0d accepted=%b, required %b", c, acc_seen, exp_acc); end
            if (acc_seen) bus_if.pkt_vld_in = 1'b0;
            checks++;
            if (bus_if.pkt_vld_out !== 4'b0100 || bus_if.pkt_data_out !== a) begin
                errors++;
                $display("FAIL bp_hold: vld=%b data=%h, required vld=0100 data=%h", bus_if.pkt_vld_out, bus_if.pkt_data_out, a);
            end
            checks++;
            if (bus_if.pkt_rdy_out !== 1'b0) begin errors++; $display("FAIL bp_rdy: cycle %0d got %b, required 0", c, bus_if.pkt_rdy_out); end
        end
        bus_if.pkt_rdy_in = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (acc_seen) bus_if.pkt_vld_in = 1'b0;
        end
        checks++;
        if ((n_deliv - base) != 2 || exp_data_q.size() != 0 || bus_if.pkt_vld_in) begin
            errors++;
            $display("FAIL bp_deliver: delivered=%0d pending=%0d, required 2 and 0", n_deliv - base, exp_data_q.size());
        end
    endtask

    task automatic test_streaming();
        int   sent;
        int   base_deliv;
        int   base_drops;
        key_t key;
        for (int i = 0; i < NUM_RREGS; i++) begin
            rt_msk[i] = key_t'($urandom) & 32'h0000_000F;
            rt_key[i] = key_t'($urandom) & rt_msk[i];
            rt_rte[i] = route_t'($urandom);
            if (i % 5 == 4) begin
                rt_msk[i] = '0;
                rt_key[i] = 32'h1;
            end
        end
        base_deliv = n_deliv;
        base_drops = exp_drops;
        key  = key_t'($urandom);
        sent = 0;
        bus_if.pkt_data_in = mk_pkt(key);
        bus_if.pkt_vld_in  = 1'b1;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            tick();
            if (acc_seen) begin
                sent++;
                key = key + 32'd1;
                bus_if.pkt_data_in = mk_pkt(key);
            end
            if (sent == 1000) bus_if.pkt_vld_in = 1'b0;
`ifdef PKT_ROUTER_SKID_EN
            begin : skid_chk
                logic rdy_pre;
                rdy_pre = bus_if.pkt_rdy_out;
                bus_if.pkt_rdy_in = ($urandom_range(0, 3) == 0) ? 4'b1111 : link_vec_t'($urandom);
                #1;
                checks++;
                if (bus_if.pkt_rdy_out !== rdy_pre) begin
                    errors++;
                    $display("FAIL skid_rdy_comb: rdy changed %b->%b with pkt_rdy_in", rdy_pre, bus_if.pkt_rdy_out);
                end
            end
`else
            bus_if.pkt_rdy_in = ($urandom_range(0, 3) == 0) ? 4'b1111 : link_vec_t'($urandom);
`endif
        end
        bus_if.pkt_vld_in = 1'b0;
        checks++;
        if (sent != 1000) begin errors++; $display("FAIL stream_timeout: sent %0d, required 1000", sent); end
        bus_if.pkt_rdy_in = 4'b1111;
        repeat (6) tick();
        checks++;
        if (exp_data_q.size() != 0 || (n_deliv - base_deliv) + (exp_drops - base_drops) != sent) begin
            errors++;
            $display("FAIL stream_complete: pending=%0d delivered=%0d dropped=%0d, required 0 pending and total %0d",
                     exp_data_q.size(), n_deliv - base_deliv, exp_drops - base_drops, sent);
        end
        checks++;
        if (drop_cnt !== 32'(exp_drops)) begin errors++; $display("FAIL stream_drops: got %0d, required %0d", drop_cnt, exp_drops); end
    endtask

    task automatic test_reset_mid();
        packet_t p, q;
        disable_all();
        rt_key[0] = '0; rt_msk[0] = '0; rt_rte[0] = 2'd1;
        bus_if.pkt_rdy_in = 4'b0000;
        p = mk_pkt(key_t'($urandom));
        q = mk_pkt(key_t'($urandom));
        bus_if.pkt_data_in = p;
        bus_if.pkt_vld_in  = 1'b1;
        tick();
        bus_if.pkt_vld_in = 1'b0;
        checks++;
        if (bus_if.pkt_vld_out !== 4'b0010) begin errors++; $display("FAIL mid_full: vld=%b, required 0010", bus_if.pkt_vld_out); end
        #1 reset_tb = 1'b0;
        #1;
        checks++;
        if (bus_if.pkt_vld_out !== '0 || bus_if.pkt_data_out !== '0 || bus_if.pkt_rdy_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: vld=%b data=%h rdy=%b, required all 0", bus_if.pkt_vld_out, bus_if.pkt_data_out, bus_if.pkt_rdy_out);
        end
        checks++;
        if (drop_cnt !== 32'd0) begin errors++; $display("FAIL mid_drop: got %0d, required 0", drop_cnt); end
        @(negedge clk_tb);
        #2 reset_tb = 1'b1;
        bus_if.pkt_rdy_in = 4'b1111;
        tick();
        checks++;
        if (bus_if.pkt_vld_out !== '0 || bus_if.pkt_rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_noflush: vld=%b rdy=%b, required 0000 and 1", bus_if.pkt_vld_out, bus_if.pkt_rdy_out);
        end
        bus_if.pkt_data_in = q;
        bus_if.pkt_vld_in  = 1'b1;
        tick();
        bus_if.pkt_vld_in = 1'b0;
        checks++;
        if (acc_seen !== 1'b1 || bus_if.pkt_vld_out !== 4'b0010 || bus_if.pkt_data_out !== q) begin
            errors++;
            $display("FAIL mid_after: acc=%b vld=%b data=%h, required 1 0010 %h", acc_seen, bus_if.pkt_vld_out, bus_if.pkt_data_out, q);
        end
        repeat (2) tick();
        checks++;
        if (exp_data_q.size() != 0) begin errors++; $display("FAIL mid_pending: %0d left, required 0", exp_data_q.size()); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_tb = 1'b1;
        bus_if.pkt_data_in = '0;
        bus_if.pkt_vld_in  = 1'b0;
        bus_if.pkt_rdy_in  = 4'b1111;
        disable_all();
        test_reset();
        test_basic_route();
        test_drop();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pkt_router.md
Name: pkt_router

Overview:
- Sits directly downstream of pkt_assembler. Accepts 72-bit SpiNNaker packets and routes each one to one of NUM_ROUTES output links.
- The route is selected by a key/mask routing table supplied by the register bank.
- Packets that match no table entry are dropped and counted.
- Single clock domain; one packet per cycle sustained throughput.

Parameters:
- PACKET_BITS, 72: packet width. Key is bits [39:8]; header is [7:0]; payload is [71:40].
- NUM_RREGS, 16: number of routing table entries.
- NUM_ROUTES, 4: number of output links.
- ROUTE_BITS, $clog2(NUM_ROUTES): width of a route field.

Ports:
- clk  in  1  block clock.
- reset_n  in  1  asynchronous, active-low reset.
- rt_key_in  in  NUM_RREGS x 32  routing entry keys.
- rt_msk_in  in  NUM_RREGS x 32  routing entry masks.
- rt_rte_in  in  NUM_RREGS x ROUTE_BITS  routing entry output link.
- pkt_data_in  in  PACKET_BITS  incoming packet.
- pkt_vld_in  in  1  incoming packet valid.
- pkt_rdy_out  out  1  ready to accept a packet.
- pkt_data_out  out  PACKET_BITS  outgoing packet, shared by all links.
- pkt_vld_out  out  NUM_ROUTES  per-link valid, one-hot or zero.
- pkt_rdy_in  in  NUM_ROUTES  per-link ready.
- drop_cnt_out  out  32  dropped-packet counter.

Behaviour:
- **Reset:** while reset_n is low, outputs are forced asynchronously to:
  - pkt_vld_out = 0
  - pkt_data_out = 0
  - pkt_rdy_out = 0
  - drop_cnt_out = 0
- **After reset:** pkt_rdy_out rises on the first clk edge after reset_n deasserts.
- **Reset mid-operation:** a held packet is discarded; it is not flushed.
- **Match rule:** entry i hits when (pkt_data_in[39:8] & rt_msk_in[i]) == rt_key_in[i]. The lowest-index hit wins.
  - An entry with msk=0 and key=0 matches everything; place it last to act as the default route.
  - An entry with msk=0 and key≠0 never matches (disabled entry).
- **Table sampling:** the routing table is sampled combinationally in the accept cycle. Table changes affect only packets accepted afterwards; a held packet keeps its route.
- **Accept:** a transfer occurs when pkt_vld_in && pkt_rdy_out. The match result and the packet are registered on that edge.
- **Output state machine:** two states.
  - EMPTY: pkt_vld_out = 0.
  - FULL: pkt_vld_out[route] = 1, pkt_data_out = held packet.
  - FULL → EMPTY when pkt_rdy_in[route] is high and no new packet is accepted.
  - EMPTY → FULL on accepting a matching packet.
  - FULL → FULL on simultaneous drain and accept (back-to-back, no bubble).
- **Ready:** pkt_rdy_out = EMPTY || pkt_rdy_in[route]. Only the selected link's ready is considered; ready from other links is ignored.
- **Latency:** 1 cycle from accept to pkt_vld_out.
- **Data stability:** pkt_data_out and pkt_vld_out are stable while stalled.
- **Drops:** a packet with no hit is accepted normally (it consumes the handshake) but never presented.
  - drop_cnt_out increments by 1 and saturates at 32'hFFFF_FFFF.
  - The output state is unchanged by a drop: a held packet stays held, and a simultaneous drain still completes.

Optional Feature:
- Macro: PKT_ROUTER_SKID_EN.
- **Defined:** adds a one-entry skid register behind the output register.
  - pkt_rdy_out becomes a pure register output (skid empty), so there is no combinational path from pkt_rdy_in to pkt_rdy_out.
  - Throughput is still 1/cycle; latency is still 1 cycle.
  - On stall, the next accepted packet lands in the skid and pkt_rdy_out drops the following cycle.
  - Order is preserved across links: the skid drains into the output register before any new packet.
- **Undefined:** pkt_rdy_out is combinational as described in Behaviour.

Decomposition:
- Shared package spif_pkg holds:
  - key/header/payload bit-position constants (KEY_LSB=8, KEY_MSB=39);
  - a packet_t typedef [PACKET_BITS-1:0];
  - a route_t typedef.
- One sub-module, pkt_router_match: purely combinational priority matcher. Inputs are the key and the table; outputs are hit and route.

Test Plan:
1. **Basic route and priority.**
   - Stimulus: entry0 key=32'hEE00_0000 msk=32'hFF00_0000 rte=2; entry1 key=0 msk=0 rte=1. Send key 32'hEE12_3456, then key 32'h1100_0001.
   - Response: first packet appears on pkt_vld_out=4'b0100 one cycle after accept; second on 4'b0010.
2. **Drop.**
   - Stimulus: all entries disabled (key=32'hFFFF_FFFF, msk=0). Send 5 packets with all pkt_rdy_in=1.
   - Response: pkt_vld_out stays 0, drop_cnt_out=5, pkt_rdy_out stays 1.
3. **Backpressure isolation.**
   - Stimulus: route 2 selected, pkt_rdy_in=4'b1011 for 10 cycles, then 4'b1111.
   - Response: packet held with data stable; pkt_rdy_out=0 (skid off) while stalled; delivered once on release; no duplication.
4. **Streaming.**
   - Stimulus: 1000 packets back-to-back with incrementing keys, random per-link ready.
   - Response: the scoreboard receives each packet exactly once, in order, on the correct link.
5. **Reset mid-stream.**
   - Stimulus: assert reset_n=0 while FULL.
   - Response: pkt_vld_out=0 immediately (async); drop_cnt_out=0; next packet after release is routed correctly.
6. **Skid variant.**
   - Stimulus: build with PKT_ROUTER_SKID_EN and rerun scenarios 3 and 4.
   - Response: identical delivered sequence; pkt_rdy_out never toggles in the same cycle as pkt_rdy_in.
